// File: rtl/pif_pkg.sv
// Shared definitions for the I2C-controlled LED flasher.
package pif_pkg;

  localparam int unsigned I2C_DATA_BITS = 6;

  // Data byte type field [7:6]
  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] D_ADDR = 2'b01;

  // Register indices
  localparam logic [5:0] REG_SCRATCH = 6'd0;
  localparam logic [5:0] REG_MODE    = 6'd2;
  localparam logic [5:0] REG_ID      = 6'd3;

  // LED mode encodings (mode[1:0])
  localparam logic [1:0] MODE_ALT  = 2'd0;
  localparam logic [1:0] MODE_SYNC = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd2;
  localparam logic [1:0] MODE_ON   = 2'd3;

  localparam logic [I2C_DATA_BITS-1:0] ID_VALUE = 6'h2A;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore,
    StRead,
    StReadAck
  } i2c_state_e;

  // Returns {red, green} for a mode and the current blink phase.
  function automatic logic [1:0] led_pattern(input logic [1:0] mode, input logic phase);
    case (mode)
      MODE_ALT:  return {phase, ~phase};
      MODE_SYNC: return {phase, phase};
      MODE_OFF:  return 2'b00;
      default:   return 2'b11;
    endcase
  endfunction

  // Readable register contents; reserved and unmapped indices read as zero.
  function automatic logic [I2C_DATA_BITS-1:0] reg_read(
    input logic [5:0]               index,
    input logic [I2C_DATA_BITS-1:0] scratch,
    input logic [I2C_DATA_BITS-1:0] mode
  );
    case (index)
      REG_SCRATCH: return scratch;
      REG_MODE:    return mode;
      REG_ID:      return ID_VALUE;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/pif_i2c_slave.sv
// I2C slave front end: input synchronizers, START/STOP detection, byte FSM.
// Define FLASHER_READBACK_EN to add register readback on R/W=1 addressing.
module pif_i2c_slave
  import pif_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h41
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
`ifdef FLASHER_READBACK_EN
  input  logic [7:0] i_rd_byte,
`endif
  output logic       o_sda_low,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data
);

  logic r_scl_s1, r_scl_s2, r_scl_prev;
  logic r_sda_s1, r_sda_s2, r_sda_prev;
  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte;

  i2c_state_e r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_sda_low;
  logic       r_byte_valid;
  logic [7:0] r_byte_data;
`ifdef FLASHER_READBACK_EN
  logic       r_rd;
  logic [7:0] r_tx;
`endif

  // Two-stage synchronizers plus a history stage for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= i_scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= i_sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
  assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_last_bit = (r_bit_cnt == 4'd7);

  // Protocol FSM; START/STOP override whatever byte is in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_sda_low    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
`ifdef FLASHER_READBACK_EN
      r_rd         <= 1'b0;
      r_tx         <= '0;
`endif
    end else begin
      r_byte_valid <= 1'b0;
      if (w_start) begin
        r_state   <= StAddr;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
      end else if (w_stop) begin
        r_state   <= StIdle;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          StAddr: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
`ifdef FLASHER_READBACK_EN
              r_rd    <= w_byte[0];
              r_state <= (w_byte[7:1] == I2C_ADDR) ? StAddrAck : StIgnore;
`else
              r_state <= (w_byte[7:1] == I2C_ADDR && !w_byte[0]) ? StAddrAck : StIgnore;
`endif
            end
          end
          // First fall after bit 8 starts the ACK, the next one ends it
          StAddrAck: if (w_scl_fall) begin
            if (!r_sda_low) begin
              r_sda_low <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= StData;
`ifdef FLASHER_READBACK_EN
              if (r_rd) begin
                r_state   <= StRead;
                r_tx      <= i_rd_byte;
                r_sda_low <= ~i_rd_byte[7];
              end
`endif
            end
          end
          StData: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= w_byte;
              r_state      <= StDataAck;
            end
          end
          StDataAck: if (w_scl_fall) begin
            if (!r_sda_low) begin
              r_sda_low <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= StData;
            end
          end
`ifdef FLASHER_READBACK_EN
          // Bit 7 is already on the bus; each fall presents the next bit
          StRead: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_state   <= StReadAck;
              end else begin
                r_sda_low <= ~r_tx[6];
                r_tx      <= {r_tx[6:0], 1'b0};
              end
            end
          end
          // Master NACK ends the read; ACK resends the same register
          StReadAck: begin
            if (w_scl_rise && r_sda_s2) begin
              r_state <= StIgnore;
            end else if (w_scl_fall) begin
              r_state   <= StRead;
              r_bit_cnt <= '0;
              r_tx      <= i_rd_byte;
              r_sda_low <= ~i_rd_byte[7];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_sda_low    = r_sda_low;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_byte_data;

endmodule

// File: rtl/pif_flasher.sv
// I2C-controlled LED blinker: register file, blink timer and LED drivers.
// Define FLASHER_READBACK_EN to enable register readback over I2C.
module pif_flasher
  import pif_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR  = 7'h41,
  parameter int unsigned BLINK_DIV = 10000000
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  SDA,
  inout  wire  SCL,
  output logic LEDR,
  output logic LEDG
);

  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic       w_sda_low;
  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic [1:0] w_type;
  logic [I2C_DATA_BITS-1:0] w_payload;
  logic       w_mode_wr;

  logic [5:0]               r_index;
  logic [I2C_DATA_BITS-1:0] r_scratch;
  logic [I2C_DATA_BITS-1:0] r_mode;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_phase;

`ifdef FLASHER_READBACK_EN
  logic [7:0] w_rd_byte;
  assign w_rd_byte = {2'b01, reg_read(r_index, r_scratch, r_mode)};
`else
  logic w_unused;
  assign w_unused = ^{r_scratch, r_mode[5:2]};
`endif

  pif_i2c_slave #(
    .I2C_ADDR (I2C_ADDR)
  ) u_i2c (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_scl        (SCL),
    .i_sda        (SDA),
`ifdef FLASHER_READBACK_EN
    .i_rd_byte    (w_rd_byte),
`endif
    .o_sda_low    (w_sda_low),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data)
  );

  // Open drain: pull low or release
  assign SDA = w_sda_low ? 1'b0 : 1'bz;

  assign w_type    = w_byte_data[7:6];
  assign w_payload = w_byte_data[I2C_DATA_BITS-1:0];
  assign w_mode_wr = w_byte_valid && (w_type == D_ADDR) && (r_index == REG_MODE);

  // Register file: index pointer plus the writable registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_index   <= '0;
      r_scratch <= '0;
      r_mode    <= '0;
    end else if (w_byte_valid) begin
      if (w_type == A_ADDR) begin
        r_index <= w_payload;
      end else if (w_type == D_ADDR) begin
        if (r_index == REG_SCRATCH) r_scratch <= w_payload;
        if (w_mode_wr)              r_mode    <= w_payload;
      end
    end
  end

  // Blink timer; a mode write restarts the pattern and beats a wrap
  always_ff @(posedge CLK) begin
    if (RST || w_mode_wr) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered LED outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      LEDR <= 1'b1;
      LEDG <= 1'b0;
    end else begin
      {LEDR, LEDG} <= led_pattern(r_mode[1:0], r_phase);
    end
  end

endmodule

// File: tb/tb_pif_flasher.sv
// Self-checking bench for pif_flasher with a short blink period.
module tb_pif_flasher;

  localparam int H = 8;  // CLK cycles per SCL half-period

  logic clk = 1'b0;
  logic rst;
  logic tb_sda_low;
  logic tb_scl;
  wire  sda;
  wire  scl;
  logic ledr, ledg;

  int checks;
  int failures;
  int    exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign scl = tb_scl;

  pif_flasher #(
    .I2C_ADDR  (7'h41),
    .BLINK_DIV (4)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .SDA  (sda),
    .SCL  (scl),
    .LEDR (ledr),
    .LEDG (ledg)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sb_push(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input int obs);
    if (exp_q.size() == 0) check_eq("sb_empty", exp_q.size(), 1);
    else check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0;
    clks(H);
    tb_scl = 1'b1;
    clks(H);
    tb_sda_low = 1'b1;
    clks(H);
    tb_scl = 1'b0;
    clks(H);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1;
    clks(H);
    tb_scl = 1'b1;
    clks(H);
    tb_sda_low = 1'b0;
    clks(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      tb_sda_low = ~b[i];
      clks(H);
      tb_scl = 1'b1;
      clks(H);
      tb_scl = 1'b0;
    end
  endtask

  // Sends a byte, samples the slave ACK (1 = ACK) into the scoreboard
  task automatic write_byte(input logic [7:0] b, input bit chk_rel);
    int ack;
    send_bits(b, 8);
    tb_sda_low = 1'b0;
    clks(H);
    tb_scl = 1'b1;
    clks(H / 2);
    ack = (sda == 1'b0) ? 1 : 0;
    clks(H / 2);
    tb_scl = 1'b0;
    sb_pop(ack);
    if (chk_rel) begin
      clks(H);
      check_eq("ack_release", int'(sda), 1);
    end
  endtask

  task automatic wr(input string tag, input logic [7:0] b, input int exp_ack);
    sb_push(tag, exp_ack);
    write_byte(b, 1'b1);
  endtask

  task automatic read_byte(input bit mack);
    logic [7:0] v;
    tb_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clks(H);
      tb_scl = 1'b1;
      clks(H / 2);
      v[i] = sda;
      clks(H / 2);
      tb_scl = 1'b0;
    end
    tb_sda_low = mack;
    clks(H);
    tb_scl = 1'b1;
    clks(H);
    tb_scl = 1'b0;
    clks(2);
    tb_sda_low = 1'b0;
    sb_pop(int'(v));
  endtask

  // Mode 0/1 blink (4 high of every 8 cycles), mode 2/3 steady
  task automatic check_leds(input int mode, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < 8) ones += int'(ledr);
      case (mode)
        0: check_eq("alt_ledg", int'(ledg), int'(!ledr));
        1: check_eq("sync_ledg", int'(ledg), int'(ledr));
        default: begin
          check_eq("steady_ledr", int'(ledr), (mode == 3) ? 1 : 0);
          check_eq("steady_ledg", int'(ledg), (mode == 3) ? 1 : 0);
        end
      endcase
    end
    if (mode < 2) check_eq("blink_duty", ones, 4);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_r;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    tb_sda_low = 1'b0;
    tb_scl     = 1'b1;
    clks(4);
    check_eq("rst_ledr", int'(ledr), 1);
    check_eq("rst_ledg", int'(ledg), 0);
    check_eq("rst_sda", int'(sda), 1);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_r = (((k - 1) / 4) % 2) == 0;
      check_eq("boot_ledr", int'(ledr), int'(exp_r));
      check_eq("boot_ledg", int'(ledg), int'(!exp_r));
      check_eq("idle_sda", int'(sda), 1);
    end

    // Mode 1: sync blink
    i2c_start(); wr("a_addr", 8'h82, 1); wr("a_idx", 8'h02, 1); wr("a_dat", 8'h41, 1);
    i2c_stop();
    check_leds(1, 16);

    // Wrong address: everything NACKed, pattern unchanged
    i2c_start(); wr("b_addr", 8'h84, 0); wr("b_idx", 8'h02, 0); wr("b_dat", 8'h43, 0);
    i2c_stop();
    check_leds(1, 16);

    // Mode 3 then mode 2 via the retained index
    i2c_start(); wr("c_addr", 8'h82, 1); wr("c_idx", 8'h02, 1); wr("c_dat", 8'h43, 1);
    i2c_stop();
    check_leds(3, 16);
    i2c_start(); wr("d_addr", 8'h82, 1); wr("d_dat", 8'h42, 1); i2c_stop();
    check_leds(2, 16);

    // Types 10/11 ACKed but ignored; index must still point at mode
    i2c_start(); wr("e_addr", 8'h82, 1); wr("e_t2", 8'h80, 1); wr("e_t3", 8'hC3, 1);
    i2c_stop();
    check_leds(2, 16);
    i2c_start(); wr("f_addr", 8'h82, 1); wr("f_dat", 8'h41, 1); i2c_stop();
    check_leds(1, 16);

    // STOP mid-byte discards it; next transaction is normal
    i2c_start(); wr("g_addr", 8'h82, 1); send_bits(8'h42, 4); i2c_stop();
    check_leds(1, 16);
    i2c_start(); wr("h_addr", 8'h82, 1); wr("h_dat", 8'h40, 1); i2c_stop();
    check_leds(0, 16);

    // ID register is read-only
    i2c_start(); wr("i_addr", 8'h82, 1); wr("i_idx", 8'h03, 1); wr("i_dat", 8'h41, 1);
`ifdef FLASHER_READBACK_EN
    i2c_start();
    sb_push("r_addr", 1); write_byte(8'h83, 1'b0);
    sb_push("rd_id", 'h6A); read_byte(1'b0);
    clks(H);
    check_eq("rd_release", int'(sda), 1);
    i2c_stop();
    i2c_start(); wr("j_addr", 8'h82, 1); wr("j_idx", 8'h02, 1);
    i2c_start();
    sb_push("r2_addr", 1); write_byte(8'h83, 1'b0);
    sb_push("rd_mode0", 'h40); read_byte(1'b1);
    sb_push("rd_mode1", 'h40); read_byte(1'b0);
    i2c_stop();
`else
    i2c_start(); wr("r_addr", 8'h83, 0); i2c_stop();
`endif
    check_leds(0, 16);

    // Reset while the slave is driving ACK
    i2c_start();
    send_bits(8'h82, 8);
    tb_sda_low = 1'b0;
    clks(H);
    check_eq("rst_ack_drive", int'(sda), 0);
    rst = 1'b1;
    clks(2);
    check_eq("rst_sda_release", int'(sda), 1);
    rst = 1'b0;
    tb_scl = 1'b1;
    clks(H);
    tb_scl = 1'b0;
    clks(H);
    wr("k_dat", 8'h43, 0);
    i2c_stop();
    check_leds(0, 16);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pif_flasher.md
Name: pif_flasher

Overview:
- I2C-controlled LED blinker: a 7-bit-address I2C slave (write-only, plus optional readback) feeding a small register file whose mode register selects the red/green LED pattern.
- Top-level board block. SDA/SCL go to the board I2C pins; LEDR/LEDG drive the board LEDs directly.

Parameters:
- I2C_ADDR, 7'h41, 7-bit slave address (8-bit write form 0x82).
- BLINK_DIV, 10000000, CLK cycles per LED half-period (0.5 s at 20 MHz); must be ≥2.

Ports:
- CLK  in  1  single system clock (20 MHz nominal); all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SDA  inout  1  open-drain data. Drive 0 or Z only.
- SCL  inout  1  open-drain clock. Always Z; no clock stretching.
- LEDR  out  1  red LED, active-high, registered.
- LEDG  out  1  green LED, active-high, registered.

Behaviour:
- SCL and SDA inputs each pass through a 2-FF synchronizer on CLK. All edge detection uses the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Either condition, repeated START included, aborts any byte in progress and returns to the address phase (START) or IDLE (STOP).
- Bytes are received MSB first, one bit sampled per SCL rising edge. Nine SCL clocks make one byte frame: 8 data bits plus ACK.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - ADDR: if byte[7:1]==I2C_ADDR and R/W=0, go to ADDR_ACK. Otherwise go to IGNORE and leave SDA released (NACK). IGNORE is held until STOP/START.
  - ACK: the slave drives SDA low from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
  - DATA bytes are always ACKed; after each ACK the FSM loops to DATA.
- Data byte format: [7:6] type, [5:0] payload (I2C_DATA_BITS=6).
  - Type 2'b00, A_ADDR: register index := payload.
  - Type 2'b01, D_ADDR: reg[index] := payload. The index does not auto-increment.
  - Types 2'b10 and 2'b11: ignored, but ACKed.
- Register commits happen on CLK in the cycle after the 8th bit is sampled. A STOP/START before the 8th bit discards the partial byte.
- Register map (index 6 bits):
  - 0: scratch, RW, reset 0.
  - 1: reserved, writes ignored.
  - 2: LED mode, RW, reset 0.
  - 3: ID, read-only 6'h2A.
  - 4–63: writes ignored.
- LED mode[1:0] (upper bits stored but ignored):
  - 0: alternating, LEDR=phase, LEDG=~phase.
  - 1: sync, LEDR=LEDG=phase.
  - 2: both off.
  - 3: both on.
- Blink: a counter counts 0..BLINK_DIV-1. On wrap, phase toggles.
- Any write to reg 2 (even the same value) clears the counter and sets phase=1 in the same cycle the register updates. The LEDs show the new pattern one CLK later.
- Reset values: FSM=IDLE, SDA released, index=0, regs as listed, counter=0, phase=1. The first registered LED values are therefore LEDR=1, LEDG=0.
- Reset asserted mid-transfer immediately releases SDA. The bus transfer is ignored until the next START.
- Simultaneous register-2 write and counter wrap: the write wins (counter=0, phase=1).

Optional Feature:
- FLASHER_READBACK_EN defined:
  - ADDR with R/W=1 and a matching address is ACKed.
  - The slave then shifts out {2'b01, reg[index]} MSB first. It drives SDA only for 0 bits, changing SDA on SCL falling edges.
  - A master ACK repeats the same register; a master NACK moves to IGNORE.
  - Reading reg 1 or index ≥4 returns 0.
- Not defined: R/W=1 address bytes are NACKed, as any mismatch.

Decomposition:
- Package pif_pkg holds:
  - I2C_DATA_BITS=6.
  - A_ADDR=2'b00, D_ADDR=2'b01.
  - Register index constants: REG_SCRATCH=0, REG_MODE=2, REG_ID=3.
  - LED mode encodings: MODE_ALT=0, MODE_SYNC=1, MODE_OFF=2, MODE_ON=3.
  - ID value 6'h2A.
- Sub-module pif_i2c_slave: synchronizers, START/STOP detection, FSM and shift register. Outputs byte_valid/byte_data and takes a readback byte input. The top level holds the registers and the blinker.

Test Plan:
- Reset, no I2C traffic, BLINK_DIV=4 → LEDR=1,LEDG=0, toggling every 4 CLK (LEDR=0,LEDG=1 next); SDA=Z throughout.
- START, 0x82, 0x02, 0x41, STOP → three ACKs (SDA low in 9th clock), mode=1, LEDR==LEDG from next CLK onward, phase restarts at 1.
- START, 0x84, 0x02, 0x43, STOP → address NACK, later bytes not ACKed, LED pattern unchanged.
- Write index 2 data 0x43 (mode 3) → LEDR=LEDG=1 steady; then data 0x42 → both 0 steady; bytes 0x80/0xC0 ACKed, no register change.
- STOP after 4 bits of data byte 0x41 → no register change; next full transaction works normally.
- FLASHER_READBACK_EN: write index 3, then repeated START 0x83 → ACK; byte read=0x6A; master NACK → SDA released; without macro 0x83 is NACKed.
